// File: rtl/alu_issue_pkg.sv
// Shared constants, decode record and decode helper for the ALU issue stage.
package alu_issue_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 16;
  localparam int unsigned RegW  = 4;

  localparam int unsigned ClsLsb = 28;
  localparam int unsigned FnLsb  = 24;
  localparam int unsigned RdLsb  = 20;
  localparam int unsigned Rs1Lsb = 16;
  localparam int unsigned Rs2Lsb = 12;

  localparam logic [3:0] ClsAlur = 4'h0;
  localparam logic [3:0] ClsCmpr = 4'h2;
  localparam logic [3:0] ClsAlui = 4'h8;
  localparam logic [3:0] ClsCmpi = 4'hA;

  localparam logic [5:0] OpAdd  = 6'h00;
  localparam logic [5:0] OpSub  = 6'h01;
  localparam logic [5:0] OpAnd  = 6'h02;
  localparam logic [5:0] OpOr   = 6'h03;
  localparam logic [5:0] OpXor  = 6'h04;
  localparam logic [5:0] OpSll  = 6'h05;
  localparam logic [5:0] OpSrl  = 6'h06;
  localparam logic [5:0] OpSra  = 6'h07;
  localparam logic [5:0] OpMvhi = 6'h08;
  localparam logic [5:0] OpF    = 6'h10;
  localparam logic [5:0] OpEq   = 6'h11;
  localparam logic [5:0] OpLt   = 6'h12;
  localparam logic [5:0] OpLe   = 6'h13;
  localparam logic [5:0] OpGtz  = 6'h1F;

  typedef struct packed {
    logic            legal;
    logic            r_form;
    logic            zext;
    logic [5:0]      opsel;
    logic [RegW-1:0] rd;
    logic [RegW-1:0] rs1;
    logic [RegW-1:0] rs2;
    logic [15:0]     imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [3:0] cls;
    logic [3:0] fn;
    cls      = inst[ClsLsb +: 4];
    fn       = inst[FnLsb +: 4];
    d.rd     = inst[RdLsb +: RegW];
    d.rs1    = inst[Rs1Lsb +: RegW];
    d.rs2    = inst[Rs2Lsb +: RegW];
    d.imm    = inst[15:0];
    d.legal  = 1'b0;
    d.r_form = 1'b0;
    d.zext   = 1'b0;
    d.opsel  = {2'b00, fn};
    case (cls)
      ClsAlur: begin
        d.legal  = (fn <= 4'd8);
        d.r_form = 1'b1;
      end
      ClsAlui: begin
        d.legal = (fn <= 4'd8);
        d.zext  = ({2'b00, fn} == OpMvhi);
      end
      ClsCmpr: begin
        d.legal  = (fn != 4'h4) && (fn != 4'hC);
        d.r_form = 1'b1;
        d.opsel  = {2'b01, fn};
      end
      ClsCmpi: begin
        d.legal = (fn != 4'h4) && (fn != 4'hC);
        d.opsel = {2'b01, fn};
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Handshake, writeback and ALU-side bundle of the issue stage.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            wb_en;
  logic [RegW-1:0] wb_reg;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      opsel;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [RegW-1:0] out_rd;
  logic            err_illegal;

  modport master (
    output in_valid, in_inst, wb_en, wb_reg, wb_data, out_ready,
    input  in_ready, out_valid, opsel, A, B, out_rd, err_illegal
  );

  modport slave (
    input  in_valid, in_inst, wb_en, wb_reg, wb_data, out_ready,
    output in_ready, out_valid, opsel, A, B, out_rd, err_illegal
  );

endinterface

// File: rtl/alu_regfile.sv
// 16x32 register file: two combinational read ports, one write port, sync reset to 0.
module alu_regfile
  import alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [RegW-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RegW-1:0] raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [RegW-1:0] raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/operand-issue stage with RAW/WAW scoreboard in front of the ALU.
// Define WB_BYPASS_EN to forward same-cycle writebacks into hazard and operand logic.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input logic        clk,
  input logic        reset_n,
  alu_issue_if.slave bus
);

  dec_t             dec;
  logic [NREGS-1:0] pending_q, pending_d, wb_mask, pend_eff;
  logic             hazard, ready, accept;
  logic [XLEN-1:0]  rdata_a, rdata_b, op_a, op_b, imm_ext;

  logic             out_valid_q;
  logic [5:0]       opsel_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [RegW-1:0]  rd_q;
  logic             err_q;

  alu_regfile u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (bus.wb_en),
    .waddr   (bus.wb_reg),
    .wdata   (bus.wb_data),
    .raddr_a (dec.rs1),
    .rdata_a (rdata_a),
    .raddr_b (dec.rs2),
    .rdata_b (rdata_b)
  );

  assign dec = decode(bus.in_inst);

  always_comb begin
    wb_mask = '0;
    if (bus.wb_en) wb_mask[bus.wb_reg] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign pend_eff = pending_q & ~wb_mask;
  assign op_a = (bus.wb_en && bus.wb_reg == dec.rs1) ? bus.wb_data : rdata_a;
  assign op_b = (bus.wb_en && bus.wb_reg == dec.rs2) ? bus.wb_data : rdata_b;
`else
  assign pend_eff = pending_q;
  assign op_a     = rdata_a;
  assign op_b     = rdata_b;
`endif

  // Illegal ops are never stalled by the scoreboard; their fields are meaningless.
  assign hazard = dec.legal & (pend_eff[dec.rs1] | (dec.r_form & pend_eff[dec.rs2]) |
                               pend_eff[dec.rd]);
  assign ready  = ~hazard & (~out_valid_q | bus.out_ready);
  assign accept = bus.in_valid & ready;

  assign imm_ext = dec.zext ? {16'h0000, dec.imm} : {{16{dec.imm[15]}}, dec.imm};

  // Set of a newly issued rd wins over a same-cycle writeback clear.
  always_comb begin
    pending_d = pending_q & ~wb_mask;
    if (accept && dec.legal) pending_d[dec.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      opsel_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (accept && dec.legal) begin
        out_valid_q <= 1'b1;
        opsel_q     <= dec.opsel;
        a_q         <= op_a;
        b_q         <= dec.r_form ? op_b : imm_ext;
        rd_q        <= dec.rd;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && !dec.legal) err_q <= 1'b1;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.opsel       = opsel_q;
  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.out_rd      = rd_q;
  assign bus.err_illegal = err_q;

endmodule
